// File: rtl/wt_dcache_refill_pkg.sv
// wt_dcache_refill_pkg: dcache geometry, refill FSM states and latched refill request type
package wt_dcache_refill_pkg;
  localparam int unsigned NumBeats = 2;
  localparam int unsigned NumSets  = 256;
  localparam int unsigned SetAssoc = 8;
  localparam int unsigned TagW     = 44;
  localparam int unsigned IdxW     = $clog2(NumSets);
  localparam int unsigned CntW     = $clog2(NumBeats);
  localparam int unsigned OffW     = CntW + 3;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, INV} refill_state_e;
  typedef struct packed {
    logic [TagW-1:0]     tag;
    logic [IdxW-1:0]     idx;
    logic [OffW-1:0]     off;
    logic [SetAssoc-1:0] way;
    logic                nc;
  } refill_req_t;
endpackage

// File: rtl/wt_dcache_refill.sv
// wt_dcache_refill: beat collector and refill/invalidate sequencer for the dcache line-write port; DCACHE_REFILL_CRITICAL_FIRST_EN selects critical-word-first beat order
module wt_dcache_refill
  import wt_dcache_refill_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_vld_i,
  output logic                     req_gnt_o,
  input  logic [TagW-1:0]          req_tag_i,
  input  logic [IdxW-1:0]          req_idx_i,
  input  logic [OffW-1:0]          req_off_i,
  input  logic [SetAssoc-1:0]      req_way_oh_i,
  input  logic                     req_nc_i,
  input  logic                     beat_vld_i,
  output logic                     beat_rdy_o,
  input  logic [63:0]              beat_data_i,
  input  logic                     inv_vld_i,
  input  logic                     inv_all_i,
  input  logic [IdxW-1:0]          inv_idx_i,
  input  logic [SetAssoc-1:0]      inv_way_oh_i,
  output logic                     inv_ack_o,
  output logic                     wr_cl_vld_o,
  output logic                     wr_cl_nc_o,
  output logic [SetAssoc-1:0]      wr_cl_we_o,
  output logic [TagW-1:0]          wr_cl_tag_o,
  output logic [IdxW-1:0]          wr_cl_idx_o,
  output logic [OffW-1:0]          wr_cl_off_o,
  output logic [64*NumBeats-1:0]   wr_cl_data_o,
  output logic [8*NumBeats-1:0]    wr_cl_data_be_o,
  output logic [SetAssoc-1:0]      wr_vld_bits_o,
  output logic                     refill_done_o
);
`ifdef DCACHE_REFILL_CRITICAL_FIRST_EN
  localparam bit CritFirst = 1'b1;
`else
  localparam bit CritFirst = 1'b0;
`endif
  refill_state_e         state_q, state_d;
  refill_req_t           req_q, req_d;
  logic [CntW-1:0]       cnt_q, cnt_d, start_w;
  logic [IdxW-1:0]       sweep_q, sweep_d, inv_idx_q, inv_idx_d;
  logic [SetAssoc-1:0]   inv_way_q, inv_way_d;
  logic                  inv_all_q, inv_all_d;
  logic [64*NumBeats-1:0] line_q, line_d;
  logic                  last_beat, sweep_end, wr_line;
  // NC beats always land at the requested word, so they share the critical-first start slot
  assign start_w   = (CritFirst || req_q.nc) ? req_q.off[OffW-1:3] : '0;
  assign last_beat = req_q.nc || (cnt_q + CntW'(1)) == start_w;
  assign sweep_end = sweep_q == IdxW'(NumSets - 1);
  assign wr_line   = state_q == WRITE && !req_q.nc;
  assign req_gnt_o       = state_q == IDLE && !inv_vld_i && req_vld_i;
  assign beat_rdy_o      = state_q == FILL;
  assign wr_cl_vld_o     = state_q == WRITE || state_q == INV;
  assign refill_done_o   = state_q == WRITE;
  assign wr_cl_nc_o      = state_q == WRITE && req_q.nc;
  assign wr_cl_we_o      = wr_line ? req_q.way : (state_q == INV) ? (inv_all_q ? '1 : inv_way_q) : '0;
  assign wr_cl_tag_o     = req_q.tag;
  assign wr_cl_idx_o     = (state_q == INV) ? (inv_all_q ? sweep_q : inv_idx_q) : req_q.idx;
  assign wr_cl_off_o     = req_q.off;
  assign wr_cl_data_o    = line_q;
  assign wr_cl_data_be_o = wr_line ? '1 : '0;
  assign wr_vld_bits_o   = wr_line ? req_q.way : '0;
  assign inv_ack_o       = state_q == INV && (!inv_all_q || sweep_end);
  // next-state: invalidation wins in IDLE, beats fill the line, sweep walks all sets
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    sweep_d   = sweep_q;
    inv_all_d = inv_all_q;
    inv_idx_d = inv_idx_q;
    inv_way_d = inv_way_q;
    line_d    = line_q;
    unique case (state_q)
      IDLE: begin
        if (inv_vld_i) begin
          state_d   = INV;
          inv_all_d = inv_all_i;
          inv_idx_d = inv_idx_i;
          inv_way_d = inv_way_oh_i;
        end else if (req_vld_i) begin
          state_d = FILL;
          req_d   = '{tag: req_tag_i, idx: req_idx_i, off: req_off_i, way: req_way_oh_i, nc: req_nc_i};
          cnt_d   = (CritFirst || req_nc_i) ? req_off_i[OffW-1:3] : '0;
        end
      end
      FILL: begin
        if (beat_vld_i) begin
          line_d[{cnt_q, 6'b0} +: 64] = beat_data_i;
          cnt_d   = cnt_q + CntW'(1);
          state_d = last_beat ? WRITE : FILL;
        end
      end
      WRITE: state_d = IDLE;
      INV: begin
        sweep_d = inv_all_q ? sweep_q + IdxW'(1) : sweep_q;
        state_d = (inv_all_q && !sweep_end) ? INV : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset drops any partially assembled line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      req_q     <= '0;
      cnt_q     <= '0;
      sweep_q   <= '0;
      inv_all_q <= 1'b0;
      inv_idx_q <= '0;
      inv_way_q <= '0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cnt_q     <= cnt_d;
      sweep_q   <= sweep_d;
      inv_all_q <= inv_all_d;
      inv_idx_q <= inv_idx_d;
      inv_way_q <= inv_way_d;
      line_q    <= line_d;
    end
  end
endmodule
